// File: rtl/wb_bus_arbiter_if.sv
// Bus bundle for wb_bus_arbiter: the per-master Wishbone request/response
// lanes on one side and the shared slave bus on the other.
// The arbiter connects through the slave modport; the environment (masters
// plus the downstream slave) drives through the master modport.
interface wb_bus_arbiter_if #(
   parameter int unsigned NUM_MASTERS = 2
);
   // master-facing lanes, master k at [W*k +: W]
   logic [NUM_MASTERS*32-1:0] m_adr_i;
   logic [NUM_MASTERS*32-1:0] m_dat_i;
   logic [NUM_MASTERS*4-1:0]  m_sel_i;
   logic [NUM_MASTERS-1:0]    m_we_i;
   logic [NUM_MASTERS-1:0]    m_cyc_i;
   logic [NUM_MASTERS-1:0]    m_stb_i;
   logic [31:0]               m_dat_o;
   logic [NUM_MASTERS-1:0]    m_ack_o;
   logic [NUM_MASTERS-1:0]    m_err_o;

   // shared slave bus
   logic [31:0]               s_adr_o;
   logic [31:0]               s_dat_o;
   logic [3:0]                s_sel_o;
   logic                      s_we_o;
   logic                      s_cyc_o;
   logic                      s_stb_o;
   logic [31:0]               s_dat_i;
   logic                      s_ack_i;

   modport slave (
      input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
      input  s_dat_i, s_ack_i,
      output m_dat_o, m_ack_o, m_err_o,
      output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
   );

   modport master (
      output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
      output s_dat_i, s_ack_i,
      input  m_dat_o, m_ack_o, m_err_o,
      input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
   );
endinterface

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: round-robin arbiter sharing one Wishbone slave bus between
// NUM_MASTERS masters. The grant is registered and held for the whole
// transfer; the granted master's request is routed to the slave and the
// ack/err are steered back to that master only.
// Optional macro WB_ARB_TIMEOUT_EN: builds a stall counter that aborts a
// transfer with a one-cycle m_err_o pulse after TIMEOUT_CYCLES unacked
// strobe cycles. Without it m_err_o is tied low and the arbiter waits forever.
module wb_bus_arbiter #(
   parameter int unsigned NUM_MASTERS    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   reset_n,
   wb_bus_arbiter_if.slave        bus,
   output logic [NUM_MASTERS-1:0] grant_o
);

   localparam int unsigned DW    = 32;
   localparam int unsigned SW    = 4;
   localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

   if (NUM_MASTERS < 2 || NUM_MASTERS > 4) begin : g_bad_num_masters
      $error("wb_bus_arbiter: NUM_MASTERS must be 2..4");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("wb_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [NUM_MASTERS-1:0] grant_d;
   logic [IDX_W-1:0]       last_q;
   logic [IDX_W-1:0]       last_d;

   // granted master's fields
   logic [DW-1:0]          g_adr;
   logic [DW-1:0]          g_dat;
   logic [SW-1:0]          g_sel;
   logic                   g_we;
   logic                   g_cyc;
   logic                   g_stb;
   logic [IDX_W-1:0]       g_idx;
   logic                   others_req;

   // arbitration result
   logic                   pick_found;
   logic [IDX_W-1:0]       pick_idx;

   logic                   busy;
   logic                   timeout;
   logic                   cyc_eff;
   logic                   stb_eff;
   logic                   ack_fwd;

   // Select the granted master's request fields and note competing requests.
   always_comb begin
      g_adr      = '0;
      g_dat      = '0;
      g_sel      = '0;
      g_we       = 1'b0;
      g_cyc      = 1'b0;
      g_stb      = 1'b0;
      g_idx      = '0;
      others_req = 1'b0;
      for (int k = 0; k < int'(NUM_MASTERS); k++) begin
         if (grant_o[k]) begin
            g_adr = bus.m_adr_i[k*DW +: DW];
            g_dat = bus.m_dat_i[k*DW +: DW];
            g_sel = bus.m_sel_i[k*SW +: SW];
            g_we  = bus.m_we_i[k];
            g_cyc = bus.m_cyc_i[k];
            g_stb = bus.m_stb_i[k];
            g_idx = IDX_W'(k);
         end else if (bus.m_cyc_i[k]) begin
            others_req = 1'b1;
         end
      end
   end

   // Round-robin pick: first requester after last_q, wrapping modulo NUM_MASTERS.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int i = 1; i <= int'(NUM_MASTERS); i++) begin
         for (int k = 0; k < int'(NUM_MASTERS); k++) begin
            if (!pick_found && bus.m_cyc_i[k] &&
                (k == (int'(last_q) + i) % int'(NUM_MASTERS))) begin
               pick_found = 1'b1;
               pick_idx   = IDX_W'(k);
            end
         end
      end
   end

   // Slave-bus handshake; a timeout suppresses cyc/stb for its cycle.
   assign busy    = (state_q == BUSY);
   assign cyc_eff = busy & g_cyc & ~timeout;
   assign stb_eff = cyc_eff & g_stb;
   assign ack_fwd = bus.s_ack_i & stb_eff;

   assign bus.s_adr_o = busy ? g_adr : '0;
   assign bus.s_dat_o = busy ? g_dat : '0;
   assign bus.s_sel_o = busy ? g_sel : '0;
   assign bus.s_we_o  = busy & g_we;
   assign bus.s_cyc_o = cyc_eff;
   assign bus.s_stb_o = stb_eff;

   assign bus.m_dat_o = bus.s_dat_i;
   assign bus.m_ack_o = grant_o & {NUM_MASTERS{ack_fwd}};
   assign bus.m_err_o = grant_o & {NUM_MASTERS{timeout}};

`ifdef WB_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign timeout = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

   // Stall counter: cleared outside BUSY and on ack, counts unacked strobes.
   always_comb begin
      cnt_d = cnt_q;
      if (!busy || timeout || ack_fwd) begin
         cnt_d = '0;
      end else if (stb_eff) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Stall counter register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // Next state: grant on any request in IDLE; release on drop, handover or timeout.
   always_comb begin
      state_d = state_q;
      grant_d = grant_o;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = BUSY;
               grant_d = NUM_MASTERS'(1) << pick_idx;
            end
         end
         BUSY: begin
            if (timeout || !g_cyc || (ack_fwd && others_req)) begin
               state_d = IDLE;
               grant_d = '0;
               last_d  = g_idx;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State, grant and round-robin pointer registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         grant_o <= '0;
         last_q  <= IDX_W'(NUM_MASTERS - 1);
      end else begin
         state_q <= state_d;
         grant_o <= grant_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter with two masters: directed reset,
// contention, table-driven read/write vectors, reset mid-transfer, a random
// phase checked against a transaction-level model, and (with
// WB_ARB_TIMEOUT_EN) a timeout sequence.
module tb_wb_bus_arbiter;

   localparam int unsigned N = 2;
`ifdef WB_ARB_TIMEOUT_EN
   localparam int unsigned TO    = 8;
   localparam bit          TO_EN = 1'b1;
`else
   localparam int unsigned TO    = 255;
   localparam bit          TO_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset_n;
   logic [N-1:0] grant;

   always #5 clk = ~clk;

   wb_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

   wb_bus_arbiter #(
      .NUM_MASTERS   (N),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus),
      .grant_o(grant)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        we;
      logic        cyc;
      logic        stb;
      logic [1:0]  ack;
      logic [1:0]  err;
      logic [1:0]  gnt;
      logic [31:0] mdat;
   } obs_t;

   typedef struct {
      string       name;
      logic [1:0]  cyc;
      logic [1:0]  stb;
      logic [1:0]  we;
      logic [63:0] adr;
      logic [63:0] dat;
      logic [7:0]  sel;
      logic        ack;
      logic [31:0] sdat;
      obs_t        exp;
   } vec_t;

   vec_t vq[$];

   function automatic obs_t mk(input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input logic we, input logic cyc,
                               input logic stb, input logic [1:0] ack, input logic [1:0] err,
                               input logic [1:0] gnt, input logic [31:0] mdat);
      return {adr, dat, sel, we, cyc, stb, ack, err, gnt, mdat};
   endfunction

   function automatic obs_t sample();
      return {bus.s_adr_o, bus.s_dat_o, bus.s_sel_o, bus.s_we_o, bus.s_cyc_o,
              bus.s_stb_o, bus.m_ack_o, bus.m_err_o, grant, bus.m_dat_o};
   endfunction

   task automatic check_obs(input string name, input obs_t exp);
      obs_t act;
      act = sample();
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got adr=%h dat=%h sel=%h we=%b cyc=%b stb=%b ack=%b err=%b gnt=%b mdat=%h ; want adr=%h dat=%h sel=%h we=%b cyc=%b stb=%b ack=%b err=%b gnt=%b mdat=%h",
                  name, act.adr, act.dat, act.sel, act.we, act.cyc, act.stb, act.ack, act.err,
                  act.gnt, act.mdat, exp.adr, exp.dat, exp.sel, exp.we, exp.cyc, exp.stb,
                  exp.ack, exp.err, exp.gnt, exp.mdat);
      end
   endtask

   task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] cyc, input logic [1:0] stb, input logic [1:0] we,
                        input logic [63:0] adr, input logic [63:0] dat, input logic [7:0] sel,
                        input logic ack, input logic [31:0] sdat);
      bus.m_cyc_i = cyc;
      bus.m_stb_i = stb;
      bus.m_we_i  = we;
      bus.m_adr_i = adr;
      bus.m_dat_i = dat;
      bus.m_sel_i = sel;
      bus.s_ack_i = ack;
      bus.s_dat_i = sdat;
   endtask

   task automatic add(input string name, input logic [1:0] cyc, input logic [1:0] stb,
                      input logic [1:0] we, input logic [63:0] adr, input logic [63:0] dat,
                      input logic [7:0] sel, input logic ack, input logic [31:0] sdat,
                      input obs_t exp);
      vec_t v;
      v.name = name; v.cyc = cyc; v.stb = stb; v.we = we; v.adr = adr; v.dat = dat;
      v.sel = sel; v.ack = ack; v.sdat = sdat; v.exp = exp;
      vq.push_back(v);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] ra, rd, wa, wd, wa2, wd2;
      int          cnt0, cnt1;
      logic [1:0]  expg;
      // model state
      int          own, last, stall;
      logic [31:0] adr_a [N];
      logic [31:0] dat_a [N];
      logic [3:0]  sel_a [N];
      logic [N-1:0] cyc, stb, we;
      logic        ack, rn, tmo, c, s, ackf, others;
      logic [31:0] sdat;
      int          pct;
      obs_t        exp;

      // ---------------- vector table ----------------
      ra = {32'h0000_0104, 32'hAAAA_0000};
      rd = {32'h0000_0000, 32'h5555_5555};
      add("rd_idle",  2'b10, 2'b10, 2'b00, ra, rd, 8'hFF, 1'b0, 32'h0,
          mk(32'h0, 32'h0, 4'h0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 32'h0));
      add("rd_wait1", 2'b10, 2'b10, 2'b00, ra, rd, 8'hFF, 1'b0, 32'h0,
          mk(32'h104, 32'h0, 4'hF, 0, 1, 1, 2'b00, 2'b00, 2'b10, 32'h0));
      add("rd_wait2", 2'b10, 2'b10, 2'b00, ra, rd, 8'hFF, 1'b0, 32'h0,
          mk(32'h104, 32'h0, 4'hF, 0, 1, 1, 2'b00, 2'b00, 2'b10, 32'h0));
      add("rd_ack",   2'b10, 2'b10, 2'b00, ra, rd, 8'hFF, 1'b1, 32'hDEADBEEF,
          mk(32'h104, 32'h0, 4'hF, 0, 1, 1, 2'b10, 2'b00, 2'b10, 32'hDEADBEEF));
      add("rd_drop",  2'b00, 2'b00, 2'b00, ra, rd, 8'hFF, 1'b0, 32'h0,
          mk(32'h104, 32'h0, 4'hF, 0, 0, 0, 2'b00, 2'b00, 2'b10, 32'h0));
      add("rd_done",  2'b00, 2'b00, 2'b00, ra, rd, 8'hFF, 1'b0, 32'h0,
          mk(32'h0, 32'h0, 4'h0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 32'h0));

      wa  = {32'h0000_3000, 32'h0000_2002};
      wd  = {32'hFFFF_0000, 32'h00AB_0000};
      wa2 = {32'h0000_3000, 32'h0000_2006};
      wd2 = {32'hFFFF_0000, 32'h1234_5678};
      add("wr_idle",   2'b01, 2'b01, 2'b01, wa, wd, 8'h14, 1'b0, 32'h0,
          mk(32'h0, 32'h0, 4'h0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 32'h0));
      add("wr_first",  2'b01, 2'b01, 2'b01, wa, wd, 8'h14, 1'b1, 32'h0,
          mk(32'h2002, 32'h00AB0000, 4'h4, 1, 1, 1, 2'b01, 2'b00, 2'b01, 32'h0));
      add("wr_second", 2'b01, 2'b01, 2'b01, wa2, wd2, 8'h1F, 1'b1, 32'h0BADF00D,
          mk(32'h2006, 32'h12345678, 4'hF, 1, 1, 1, 2'b01, 2'b00, 2'b01, 32'h0BADF00D));
      add("wr_nostb",  2'b01, 2'b00, 2'b01, wa2, wd2, 8'h1F, 1'b1, 32'h0,
          mk(32'h2006, 32'h12345678, 4'hF, 1, 1, 0, 2'b00, 2'b00, 2'b01, 32'h0));
      add("wr_drop",   2'b00, 2'b00, 2'b01, wa2, wd2, 8'h1F, 1'b0, 32'h0,
          mk(32'h2006, 32'h12345678, 4'hF, 1, 0, 0, 2'b00, 2'b00, 2'b01, 32'h0));
      add("wr_done",   2'b00, 2'b00, 2'b01, wa2, wd2, 8'h1F, 1'b0, 32'h0,
          mk(32'h0, 32'h0, 4'h0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 32'h0));

      // ---------------- reset with both masters requesting ----------------
      reset_n = 1'b0;
      drive(2'b11, 2'b11, 2'b00, 64'h0, 64'h0, 8'hFF, 1'b1, 32'h1111_2222);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #2;
         check_obs("reset_hold", mk(32'h0, 32'h0, 4'h0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 32'h1111_2222));
      end
      @(posedge clk); #1 reset_n = 1'b1; #1;
      check_obs("reset_release", mk(32'h0, 32'h0, 4'h0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 32'h1111_2222));

      // ---------------- contention: 4 transfers each, ack every cycle ----------------
      cnt0 = 0; cnt1 = 0;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); #1;
         bus.m_cyc_i = {cnt1 < 4, cnt0 < 4};
         bus.m_stb_i = {cnt1 < 4, cnt0 < 4};
         #1;
         if (i <= 15) begin
            expg = (i % 2 == 1) ? ((i % 4 == 1) ? 2'b01 : 2'b10) : 2'b00;
            check_val("contention_grant", 64'(grant), 64'(expg));
            check_val("contention_ack", 64'(bus.m_ack_o), 64'(expg));
         end else begin
            check_val("contention_last_grant", 64'(grant), 64'(2'b10));
            check_val("contention_last_cyc", 64'(bus.s_cyc_o), 64'(1'b0));
         end
         cnt0 += int'(bus.m_ack_o[0]);
         cnt1 += int'(bus.m_ack_o[1]);
      end
      check_val("contention_acks_m0", 64'(cnt0), 64'd4);
      check_val("contention_acks_m1", 64'(cnt1), 64'd4);

      // ---------------- table-driven read / write vectors ----------------
      foreach (vq[j]) begin
         @(posedge clk); #1;
         drive(vq[j].cyc, vq[j].stb, vq[j].we, vq[j].adr, vq[j].dat, vq[j].sel,
               vq[j].ack, vq[j].sdat);
         #1;
         check_obs(vq[j].name, vq[j].exp);
      end

      // ---------------- reset mid-transfer (last owner was m0) ----------------
      @(posedge clk); #1;
      drive(2'b01, 2'b01, 2'b00, wa, wd, 8'hFF, 1'b0, 32'h0);
      #1 check_val("midrst_idle_grant", 64'(grant), 64'(2'b00));
      @(posedge clk); #1 reset_n = 1'b0; #1;
      check_val("midrst_granted_cyc", 64'(bus.s_cyc_o), 64'(1'b1));
      check_val("midrst_granted_ack", 64'(bus.m_ack_o), 64'(2'b00));
      @(posedge clk); #1;
      reset_n     = 1'b1;
      bus.m_cyc_i = 2'b11;
      bus.m_stb_i = 2'b11;
      #1;
      check_val("midrst_cyc_dropped", 64'(bus.s_cyc_o), 64'(1'b0));
      check_val("midrst_no_ack", 64'({bus.m_ack_o, grant}), 64'(4'b0000));
      @(posedge clk); #2;
      check_val("midrst_rr_pointer", 64'(grant), 64'(2'b01));
      @(posedge clk); #1 drive(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b0, 32'h0);

      // ---------------- random phase against a transaction model ----------------
      @(posedge clk); #1 reset_n = 1'b0;
      own = -1; last = N - 1; stall = 0;
      pct = 50;
      for (int t = 0; t < 3000; t++) begin
         if (t % 150 == 0) pct = int'($urandom_range(5, 95));
         rn = ($urandom_range(0, 79) != 0);
         for (int k = 0; k < N; k++) begin
            cyc[k]   = ($urandom_range(0, 99) < 65);
            stb[k]   = ($urandom_range(0, 99) < 80);
            we[k]    = 1'($urandom_range(0, 1));
            adr_a[k] = $urandom;
            dat_a[k] = $urandom;
            sel_a[k] = 4'($urandom_range(0, 15));
         end
         ack  = (int'($urandom_range(0, 99)) < pct);
         sdat = $urandom;
         @(posedge clk); #1;
         reset_n = rn;
         bus.m_cyc_i = cyc;
         bus.m_stb_i = stb;
         bus.m_we_i  = we;
         for (int k = 0; k < N; k++) begin
            bus.m_adr_i[k*32 +: 32] = adr_a[k];
            bus.m_dat_i[k*32 +: 32] = dat_a[k];
            bus.m_sel_i[k*4 +: 4]   = sel_a[k];
         end
         bus.s_ack_i = ack;
         bus.s_dat_i = sdat;
         #1;
         // expected outputs for the current owner
         exp  = mk(32'h0, 32'h0, 4'h0, 0, 0, 0, 2'b00, 2'b00, 2'b00, sdat);
         tmo  = 1'b0;
         ackf = 1'b0;
         s    = 1'b0;
         if (own >= 0) begin
            tmo = TO_EN && (stall == int'(TO));
            c   = cyc[own] && !tmo;
            s   = c && stb[own];
            ackf = ack && s;
            exp.adr = adr_a[own];
            exp.dat = dat_a[own];
            exp.sel = sel_a[own];
            exp.we  = we[own];
            exp.cyc = c;
            exp.stb = s;
            exp.ack[own] = ackf;
            exp.err[own] = tmo;
            exp.gnt[own] = 1'b1;
         end
         check_obs("random", exp);
         // advance the model to the next edge
         if (!rn) begin
            own = -1; last = N - 1; stall = 0;
         end else if (own < 0) begin
            for (int i = 1; i <= N; i++) begin
               if (own < 0 && cyc[(last + i) % N]) begin
                  own   = (last + i) % N;
                  stall = 0;
               end
            end
         end else begin
            others = 1'b0;
            for (int k = 0; k < N; k++) if (k != own && cyc[k]) others = 1'b1;
            if (tmo || !cyc[own] || (ackf && others)) begin
               last  = own;
               own   = -1;
               stall = 0;
            end else if (ackf) begin
               stall = 0;
            end else if (s) begin
               stall++;
            end
         end
      end

`ifdef WB_ARB_TIMEOUT_EN
      // ---------------- timeout: slave never acks m0, m1 pending ----------------
      @(posedge clk); #1 reset_n = 1'b0;
      drive(2'b11, 2'b11, 2'b00, 64'h0, 64'h0, 8'hFF, 1'b0, 32'h0);
      @(posedge clk); #1 reset_n = 1'b1;
      #1 check_val("to_idle_grant", 64'(grant), 64'(2'b00));
      for (int st = 1; st <= 9; st++) begin
         @(posedge clk); #2;
         check_val("to_grant", 64'(grant), 64'(2'b01));
         if (st < 9) begin
            check_val("to_no_err", 64'({bus.m_err_o, bus.s_cyc_o}), 64'(3'b001));
         end else begin
            check_val("to_err_pulse", 64'({bus.m_err_o, bus.s_cyc_o, bus.s_stb_o}), 64'(4'b0100));
         end
      end
      @(posedge clk); #2;
      check_val("to_back_idle", 64'({grant, bus.m_err_o}), 64'(4'b0000));
      @(posedge clk); #2;
      check_val("to_m1_next", 64'(grant), 64'(2'b10));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Shares one Wishbone slave bus between NUM_MASTERS Wishbone masters, e.g. the instruction-fetch port and the data-side wishbone_controller.
- Round-robin arbitration; the grant is registered and held for the whole transfer.
- The granted master's request is routed to the slave. Ack, and err when enabled, are steered back to that master only.
- Sits between core-side bus controllers and the memory/peripheral interconnect.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..4).
- TIMEOUT_CYCLES, 255, cycles without ack before a bus error; used only with WB_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- m_adr_i  in  NUM_MASTERS*32  per-master address, master k at [32k+31:32k]
- m_dat_i  in  NUM_MASTERS*32  per-master write data
- m_sel_i  in  NUM_MASTERS*4  per-master byte enables
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_cyc_i  in  NUM_MASTERS  per-master cycle request
- m_stb_i  in  NUM_MASTERS  per-master strobe
- m_dat_o  out  32  read data, broadcast to all masters
- m_ack_o  out  NUM_MASTERS  per-master acknowledge
- m_err_o  out  NUM_MASTERS  per-master bus error
- s_adr_o  out  32  slave address
- s_dat_o  out  32  slave write data
- s_sel_o  out  4  slave byte enables
- s_we_o  out  1  slave write enable
- s_cyc_o  out  1  slave cycle valid
- s_stb_o  out  1  slave strobe
- s_dat_i  in  32  slave read data
- s_ack_i  in  1  slave acknowledge
- grant_o  out  NUM_MASTERS  one-hot current grant (debug)

Behaviour:
- Single clock clk. Reset is synchronous and active-low on reset_n.
- Reset state: state=IDLE, grant_o=0, last_grant=NUM_MASTERS-1 (master 0 wins first).
- Reset outputs: s_cyc_o=0, s_stb_o=0, s_we_o=0, s_adr_o=0, s_dat_o=0, s_sel_o=0, m_ack_o=0, m_err_o=0.
- FSM states: IDLE, BUSY.
- IDLE: if any m_cyc_i is high, pick the first requester scanning from last_grant+1 (mod NUM_MASTERS) upward. Register it one-hot into grant_o and go to BUSY on the next edge.
- IDLE with no request: stay in IDLE. s_ack_i is ignored in IDLE.
- Arbitration latency: 1 cycle. A request at cycle N appears on the slave bus at cycle N+1.
- BUSY routing, combinational from grant_o: s_adr/dat/sel/we are the granted master's fields. s_cyc_o = m_cyc_i[g]. s_stb_o = m_stb_i[g] & m_cyc_i[g].
- In IDLE the s_* outputs are all zero.
- m_ack_o[g] = s_ack_i & s_stb_o. Every other m_ack_o bit is 0. m_dat_o = s_dat_i at all times.
- BUSY exit, granted master drops m_cyc_i: go to IDLE, last_grant<=g, grant_o<=0.
- BUSY exit, handover: s_ack_i is high and any other master has m_cyc_i high. Go to IDLE and set last_grant<=g. The granted master's next access then competes in the next arbitration, which prevents a back-to-back master starving the others.
- BUSY, ack with no other requester: stay in BUSY with the same grant. Back-to-back accesses then have zero dead cycles.
- Simultaneous requests in IDLE: round-robin order strictly rotates. With 2 masters both always requesting, grants alternate 0,1,0,1.
- Ungranted masters keep m_ack_o=0, so their controllers stall.
- Reset mid-transfer: the s_cyc_o/s_stb_o drop is seen on the cycle after reset_n is sampled low. The pending transfer is abandoned with no ack.
- s_ack_i with s_stb_o low is not forwarded.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro: a counter of clog2(TIMEOUT_CYCLES+1) bits clears on grant and on each ack. It increments each BUSY cycle with s_stb_o=1 and s_ack_i=0.
- When the counter equals TIMEOUT_CYCLES: m_err_o[g] pulses high for 1 cycle, s_cyc_o/s_stb_o are forced to 0 that cycle, the FSM goes to IDLE and last_grant<=g.
- Without the macro: the counter is not built, m_err_o is constant 0, and the arbiter waits indefinitely for ack.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with m_cyc_i=2'b11 -> all s_* = 0, grant_o=0. Release reset -> grant_o=2'b01 one cycle later.
- Single master: m1 reads adr 0x0000_0104, slave acks after 2 wait cycles with s_dat_i=0xDEADBEEF -> s_adr_o=0x104 from cycle N+1, m_ack_o=2'b10 for exactly 1 cycle, m_dat_o=0xDEADBEEF, m_ack_o[0] stays 0.
- Contention: both masters hold cyc/stb for 4 transfers each, slave acks every cycle -> grant sequence 0,1,0,1,..., each master gets exactly 4 acks, 1 idle cycle between handovers.
- Write routing: m0 writes sel=4'b0100, dat=0x00AB0000, adr=0x2002 while m1 is idle -> s_we_o=1, s_sel_o=4'b0100, s_dat_o=0x00AB0000. FSM stays in BUSY across a back-to-back second m0 write.
- Reset mid-transfer: assert reset_n=0 while m0 is granted and the slave is stalling -> s_cyc_o=0 on the next cycle, no m_ack_o pulse, last_grant=1.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave never acks m0 -> m_err_o=2'b01 for 1 cycle in the 9th stalled cycle (counter reaches 8), FSM in IDLE, and a pending m1 is granted next.
